cic_decim_comb: RTL

- Decimate-and-comb back end of the CIC decimator; sits directly downstream of the integrator stage and consumes its I/Q accumulator outputs and valid.
- Keeps one of every R valid input samples, runs NUM_STAGES pipelined comb (differentiator) stages with differential delay 1, then truncates to OUT_WIDTH.
- Output feeds the compensation filter or packetiser at the decimated rate.

---
 rtl/cic_decim_comb.sv | 110 +++++++++++
 1 files changed

// File: rtl/cic_decim_comb.sv
// cic_decim_comb: decimate-by-R and NUM_STAGES comb back end of a CIC decimator (I/Q)
// Ports:
//   i_clock                  single clock
//   i_reset_n                asynchronous active-low reset
//   i_rate                   decimation factor R (0 and 1 keep every sample)
//   i_inph_data/i_quad_data  integrator outputs, i_valid sample strobe
//   o_inph_data/o_quad_data  combed samples at the decimated rate, o_valid one-cycle strobe
// Optional: define CIC_DECIM_COMB_ROUND_EN to round half up (saturating) instead of truncating.
module cic_decim_comb #(
    parameter int WIDTH      = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int NUM_STAGES = 3,
    parameter int RATE_WIDTH = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [RATE_WIDTH-1:0] i_rate,
    input  logic [WIDTH-1:0]      i_inph_data,
    input  logic [WIDTH-1:0]      i_quad_data,
    input  logic                  i_valid,
    output logic [OUT_WIDTH-1:0]  o_inph_data,
    output logic [OUT_WIDTH-1:0]  o_quad_data,
    output logic                  o_valid
);
    logic [RATE_WIDTH-1:0]                 cnt, rate_q, cnt_inc;
    logic                                  accept;
    logic [NUM_STAGES:0][WIDTH-1:0]        x_i, x_q;
    logic [NUM_STAGES-1:0][WIDTH-1:0]      d_i, d_q;
    logic [NUM_STAGES:0]                   v;
    logic [OUT_WIDTH-1:0]                  r_i, r_q;

    assign accept  = i_valid && cnt == '0;
    assign cnt_inc = cnt + RATE_WIDTH'(1);

    // rate is latched only on accept so a mid-frame change waits for the frame boundary
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt    <= '0;
            rate_q <= '0;
        end else if (i_valid) begin
            if (accept) begin
                rate_q <= i_rate;
                cnt    <= (i_rate > RATE_WIDTH'(1)) ? RATE_WIDTH'(1) : '0;
            end else begin
                cnt    <= (cnt_inc == rate_q) ? '0 : cnt_inc;
            end
        end
    end

    // x[0] is the accept register, x[k] the result of comb stage k, d[k-1] its delay
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            x_i <= '0;
            x_q <= '0;
            d_i <= '0;
            d_q <= '0;
            v   <= '0;
        end else begin
            v[0] <= accept;
            if (accept) begin
                x_i[0] <= i_inph_data;
                x_q[0] <= i_quad_data;
            end
            for (int k = 1; k <= NUM_STAGES; k++) begin
                v[k] <= v[k-1];
                if (v[k-1]) begin
                    x_i[k]   <= x_i[k-1] - d_i[k-1];
                    x_q[k]   <= x_q[k-1] - d_q[k-1];
                    d_i[k-1] <= x_i[k-1];
                    d_q[k-1] <= x_q[k-1];
                end
            end
        end
    end

`ifdef CIC_DECIM_COMB_ROUND_EN
    if (OUT_WIDTH < WIDTH) begin : g_round
        localparam logic [WIDTH-1:0] HALF = WIDTH'(1) << (WIDTH - OUT_WIDTH - 1);
        localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        logic [WIDTH-1:0] s_i, s_q;
        // only a non-negative value can overflow when adding the positive half LSB
        always_comb begin
            s_i = x_i[NUM_STAGES] + HALF;
            s_q = x_q[NUM_STAGES] + HALF;
            r_i = (!x_i[NUM_STAGES][WIDTH-1] && s_i[WIDTH-1]) ? MAX_POS : s_i[WIDTH-1 -: OUT_WIDTH];
            r_q = (!x_q[NUM_STAGES][WIDTH-1] && s_q[WIDTH-1]) ? MAX_POS : s_q[WIDTH-1 -: OUT_WIDTH];
        end
    end else begin : g_trunc
        assign r_i = x_i[NUM_STAGES][WIDTH-1 -: OUT_WIDTH];
        assign r_q = x_q[NUM_STAGES][WIDTH-1 -: OUT_WIDTH];
    end
`else
    assign r_i = x_i[NUM_STAGES][WIDTH-1 -: OUT_WIDTH];
    assign r_q = x_q[NUM_STAGES][WIDTH-1 -: OUT_WIDTH];
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_inph_data <= '0;
            o_quad_data <= '0;
            o_valid     <= 1'b0;
        end else begin
            o_valid <= v[NUM_STAGES];
            if (v[NUM_STAGES]) begin
                o_inph_data <= r_i;
                o_quad_data <= r_q;
            end
        end
    end
endmodule
